uart_rx_oversampler: RTL and testbench



---
 rtl/uart_rx_oversampler.sv | 143 ++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 2-FF synchronised input, 3-sample mid-bit majority vote, false-start rejection,
// framing/break detection and a line-idle strobe once the line rests after a received byte.
module uart_rx_oversampler #(
  parameter int unsigned CLK_FREQ  = 48_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned IDLE_BITS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       line_idle
);

  localparam int unsigned CPB = CLK_FREQ / BAUD;
  localparam int unsigned MID = CPB / 2;
  localparam int unsigned TW  = $clog2(CPB);

  localparam logic [TW-1:0] TmrEarly  = TW'(MID - 1);
  localparam logic [TW-1:0] TmrMid    = TW'(MID);
  localparam logic [TW-1:0] TmrDecide = TW'(MID + 1);
  localparam logic [TW-1:0] TmrLast   = TW'(CPB - 1);
  localparam logic [31:0]   IdleTerm  = 32'(IDLE_BITS * CPB);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitMark} state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [1:0]    samp_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          break_q;
  logic          line_idle_q;
  logic          armed_q;
  logic [31:0]   idle_cnt_q;

  logic rx_s;
  logic vote;
  logic decide;
  logic wrap;

  assign rx_s   = sync_q[1];
  // Third sample is the live synchronised value at the decision point.
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign decide = (timer_q == TmrDecide);
  assign wrap   = (timer_q == TmrLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      line_idle_q <= 1'b0;
      armed_q     <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      line_idle_q <= 1'b0;

      if (state_q == StIdle && rx_s) begin
        if (idle_cnt_q != IdleTerm) idle_cnt_q <= idle_cnt_q + 32'd1;
        if (armed_q && idle_cnt_q == IdleTerm - 32'd1) begin
          line_idle_q <= 1'b1;
          armed_q     <= 1'b0;
        end
      end else begin
        idle_cnt_q <= '0;
      end

      if (state_q inside {StStart, StData, StStop}) begin
        timer_q <= wrap ? '0 : timer_q + 1'b1;
        if (timer_q == TmrEarly) samp_q[0] <= rx_s;
        if (timer_q == TmrMid)   samp_q[1] <= rx_s;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q   <= StStart;
            timer_q   <= '0;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (decide && vote) state_q <= StIdle;
          else if (wrap)      state_q <= StData;
        end
        StData: begin
          if (decide) shift_q <= {vote, shift_q[7:1]};
          if (wrap) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          // Leave at the decision point so a fast sender's next start bit is not missed.
          if (decide) begin
            if (vote) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              armed_q    <= 1'b1;
              state_q    <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              break_q     <= (shift_q == 8'h00);
              state_q     <= StWaitMark;
            end
          end
        end
        StWaitMark: begin
          if (rx_s) begin
            break_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign break_det = break_q;
  assign line_idle = line_idle_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler: vector table, directed corner cases and
// randomized frames checked against a timing model derived from the frame parameters.
module tb_uart_rx_oversampler;

  localparam int unsigned CLK_FREQ  = 6_400_000;
  localparam int unsigned BAUD      = 100_000;
  localparam int unsigned IDLE_BITS = 10;
  localparam int CPB  = 64;
  localparam int MID  = 32;
  localparam int TERM = 640;
  // Cycle (relative to the cycle the start bit is driven) at which a stop strobe is visible.
  localparam int STROBE_LAT = 9 * CPB + MID + 5;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       break_det;
  logic       line_idle;

  uart_rx_oversampler #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .break_det(break_det),
    .line_idle(line_idle)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         overlap_cnt = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  int         fq_cyc[$];
  int         iq_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq_data.push_back(rx_data);
      vq_cyc.push_back(cyc);
    end
    if (frame_err) fq_cyc.push_back(cyc);
    if (line_idle) iq_cyc.push_back(cyc);
    if ((rx_valid && frame_err) || (rx_valid && line_idle)) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one frame with bit period p cycles; lim >= 0 truncates it after lim cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input real p, input int lim,
                            output int t0);
    logic [9:0] bits;
    int n;
    int k;
    bits = {stop, d, 1'b0};
    n = $rtoi(10.0 * p);
    if (lim >= 0 && lim < n) n = lim;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      k = $rtoi(real'(i) / p);
      rx = bits[k];
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag, output int t0);
    vq_data.delete();
    vq_cyc.delete();
    fq_cyc.delete();
    send_frame(v.data, v.stop, real'(CPB), -1, t0);
    check({tag, " valid_count"}, vq_data.size(), v.exp_valid);
    if (v.exp_valid && vq_data.size() > 0) begin
      check({tag, " data"}, vq_data[0], v.data);
      check({tag, " valid_cycle"}, vq_cyc[0], t0 + STROBE_LAT);
    end
    check({tag, " ferr_count"}, fq_cyc.size(), v.exp_ferr);
    if (v.exp_ferr && fq_cyc.size() > 0) check({tag, " ferr_cycle"}, fq_cyc[0], t0 + STROBE_LAT);
    check({tag, " break_in_stop"}, break_det, v.exp_brk);
    if (v.exp_valid) last_good = v.data;
    check({tag, " rx_data_held"}, rx_data, last_good);
    idle_cycles(v.gap * CPB);
    if (v.gap > 0) check({tag, " break_cleared"}, break_det, 1'b0);
  endtask

  vec_t vecs[7];
  vec_t v;
  int   t0;
  int   rr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 2, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset break_det", break_det, 1'b0);
    check("reset line_idle", line_idle, 1'b0);
    rst = 1'b0;

    // Mark without any received byte must not produce line_idle.
    idle_cycles(TERM + 2 * CPB);
    check("no idle before byte", iq_cyc.size(), 0);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i), t0);

    // Back-to-back frames at +3.5% then -3.5% baud.
    for (int s = 0; s < 2; s++) begin
      real p;
      p = (s == 0) ? real'(CPB) / 1.035 : real'(CPB) * 1.035;
      vq_data.delete();
      fq_cyc.delete();
      send_frame(8'h00, 1'b1, p, -1, t0);
      send_frame(8'hFF, 1'b1, p, -1, t0);
      send_frame(8'h55, 1'b1, p, -1, t0);
      idle_cycles(2 * CPB);
      check($sformatf("skew%0d count", s), vq_data.size(), 3);
      if (vq_data.size() == 3) begin
        check($sformatf("skew%0d byte0", s), vq_data[0], 8'h00);
        check($sformatf("skew%0d byte1", s), vq_data[1], 8'hFF);
        check($sformatf("skew%0d byte2", s), vq_data[2], 8'h55);
      end
      check($sformatf("skew%0d ferr", s), fq_cyc.size(), 0);
      last_good = 8'h55;
    end

    // Glitches: short low of MID-2 cycles, then a single-cycle low pulse.
    vq_data.delete();
    fq_cyc.delete();
    rx = 1'b0;
    repeat (MID - 2) begin
      @(posedge clk); #1;
    end
    idle_cycles(2 * CPB);
    rx = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2 * CPB);
    check("glitch valid", vq_data.size(), 0);
    check("glitch ferr", fq_cyc.size(), 0);
    check("glitch rx_data", rx_data, last_good);
    v = '{8'h96, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    apply_vec(v, "post_glitch", t0);

    // Break: 20 bit times low.
    vq_data.delete();
    fq_cyc.delete();
    t0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      if (cyc == t0 + STROBE_LAT - 1) check("break before stop", break_det, 1'b0);
      if (cyc == t0 + STROBE_LAT)     check("break at stop", break_det, 1'b1);
      @(posedge clk); #1;
    end
    check("break held", break_det, 1'b1);
    check("break ferr count", fq_cyc.size(), 1);
    if (fq_cyc.size() > 0) check("break ferr cycle", fq_cyc[0], t0 + STROBE_LAT);
    check("break valid", vq_data.size(), 0);
    rx = 1'b1;
    @(posedge clk); #1;
    check("break after rise+1", break_det, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("break after rise+4", break_det, 1'b0);
    idle_cycles(CPB);
    v = '{8'h12, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    apply_vec(v, "post_break", t0);

    // Idle strobe: one byte then mark.
    iq_cyc.delete();
    v = '{8'h5E, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    apply_vec(v, "idle_byte", t0);
    idle_cycles(TERM);
    check("idle count", iq_cyc.size(), 1);
    if (iq_cyc.size() > 0) check("idle cycle", iq_cyc[0], t0 + STROBE_LAT + TERM);
    idle_cycles(2 * TERM);
    check("idle no repeat", iq_cyc.size(), 1);

    // Reset during DATA.
    v = '{8'hC3, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    apply_vec(v, "pre_reset", t0);
    vq_data.delete();
    fq_cyc.delete();
    send_frame(8'h5A, 1'b1, real'(CPB), 4 * CPB, t0);
    #2;
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("midrst rx_data", rx_data, 8'h00);
    check("midrst rx_valid", rx_valid, 1'b0);
    check("midrst frame_err", frame_err, 1'b0);
    check("midrst break_det", break_det, 1'b0);
    check("midrst line_idle", line_idle, 1'b0);
    last_good = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(12 * CPB);
    check("midrst no valid", vq_data.size(), 0);
    check("midrst no ferr", fq_cyc.size(), 0);
    v = '{8'h6B, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    apply_vec(v, "post_reset", t0);

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) begin
      rr          = $urandom;
      v.data      = rr[7:0];
      v.stop      = ($urandom_range(0, 5) != 0);
      v.gap       = v.stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      v.exp_valid = v.stop;
      v.exp_ferr  = !v.stop;
      v.exp_brk   = !v.stop && (v.data == 8'h00);
      apply_vec(v, $sformatf("rand%0d", i), t0);
    end

    check("strobe overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
